// File: rtl/apb4_mem_slave.sv
// ---------------------------------------------------------------------------
// apb4_mem_slave
//   APB4 completer that fronts a word-organised memory with byte strobes and
//   a fixed, parameterised number of wait states per transfer.
//
// Parameters
//   ADDR_W      : PADDR width (byte address)
//   DATA_W      : data width, one of 8/16/32/64
//   DEPTH       : memory depth in words (power of two, at least 2)
//   WAIT_CYCLES : wait states inserted in every access phase (0..15)
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   psel     : slave select
//   penable  : access phase
//   pwrite   : 1 = write, 0 = read
//   paddr    : byte address, low offset bits ignored
//   pwdata   : write data
//   pstrb    : byte write strobes (ignored on reads)
//   prdata   : registered read data
//   pready   : registered transfer-complete flag, one cycle per transfer
//   pslverr  : registered error response
//
// Build option
//   APB4_MEM_SLAVE_PSLVERR_EN : when defined, a word index >= DEPTH returns
//   an error response and suppresses the write; when undefined, pslverr is
//   always 0 and the word index wraps modulo DEPTH.
// ---------------------------------------------------------------------------
module apb4_mem_slave #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_nxt_s;
  logic              pready_r;
  logic              pready_nxt_s;
  logic              pslverr_r;
  logic              pslverr_nxt_s;
  logic [DATA_W-1:0] prdata_r;
  logic [DATA_W-1:0] prdata_nxt_s;

  logic [IDX_W-1:0]  word_idx_s;
  logic              oob_s;
  logic [DATA_W-1:0] rd_word_s;
  logic              load_s;
  logic              wr_en_s;

  // Truncation to IDX_W gives the modulo-DEPTH wrap for free.
  assign word_idx_s = IDX_W'(paddr >> OFF_W);
  assign rd_word_s  = mem_r[word_idx_s];

`ifdef APB4_MEM_SLAVE_PSLVERR_EN
  // Any address bit above the word index field means index >= DEPTH.
  assign oob_s = |(paddr >> (OFF_W + IDX_W));
`else
  assign oob_s = 1'b0;
`endif

  // Next-state, wait counter and output-register computation.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    pready_nxt_s  = pready_r;
    pslverr_nxt_s = pslverr_r;
    prdata_nxt_s  = prdata_r;
    load_s        = 1'b0;
    wr_en_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // Only a proper setup phase starts a transfer; psel&penable here is ignored.
        if (psel && !penable) begin
          state_nxt_s = ST_ACCESS;
          cnt_nxt_s   = WAIT_LD;
          load_s      = (WAIT_LD == 4'd0);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: no write, no pready.
          state_nxt_s   = ST_IDLE;
          cnt_nxt_s     = 4'd0;
          pready_nxt_s  = 1'b0;
          pslverr_nxt_s = 1'b0;
        end else if (pready_r) begin
          if (penable) begin
            // Completion edge.
            state_nxt_s   = ST_IDLE;
            pready_nxt_s  = 1'b0;
            pslverr_nxt_s = 1'b0;
            if (pwrite) begin
              prdata_nxt_s = '0;
              wr_en_s      = !oob_s;
            end else begin
              prdata_nxt_s = prdata_r;
            end
          end else begin
            state_nxt_s = ST_ACCESS;
          end
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
          load_s    = (cnt_r == 4'd1);
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        cnt_nxt_s     = 4'd0;
        pready_nxt_s  = 1'b0;
        pslverr_nxt_s = 1'b0;
      end
    endcase

    // Entering the last access cycle: raise pready with the response
    // already registered so it lines up with pready.
    if (load_s) begin
      pready_nxt_s  = 1'b1;
      pslverr_nxt_s = oob_s;
      if (oob_s) begin
        prdata_nxt_s = '0;
      end else if (!pwrite) begin
        prdata_nxt_s = rd_word_s;
      end else begin
        prdata_nxt_s = prdata_r;
      end
    end else begin
      prdata_nxt_s = prdata_nxt_s;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= '0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pready_r  <= pready_nxt_s;
      pslverr_r <= pslverr_nxt_s;
      prdata_r  <= prdata_nxt_s;
    end
  end

  // Storage array; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (wr_en_s && pstrb[b]) begin
        mem_r[word_idx_s][b*8 +: 8] <= pwdata[b*8 +: 8];
      end
    end
  end

  assign prdata  = prdata_r;
  assign pready  = pready_r;
  assign pslverr = pslverr_r;

endmodule

// File: tb/tb_apb4_mem_slave.sv
module tb_apb4_mem_slave;

  logic        clk;
  logic        rst_n;
  logic        psel0, psel3;
  logic        penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;

  // Two instances: index 0 = zero-wait, index 1 = three wait states.
  apb4_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  apb4_mem_slave #(.ADDR_W(12), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Transaction-level model state.
  logic [31:0] mdl [2][256];
  logic [31:0] exp_prdata [2];
  logic        exp_pready [2];
  logic        exp_pslverr [2];

  bit          pend_v;
  int          pend_d;
  bit          pend_wr, pend_oob;
  int          pend_idx;
  logic [31:0] pend_data;
  logic [3:0]  pend_strb;

  function automatic int idx_of(input logic [11:0] a);
    return (int'(a) / 4) % 256;
  endfunction

  function automatic bit oob_of(input logic [11:0] a);
`ifdef APB4_MEM_SLAVE_PSLVERR_EN
    return (int'(a) / 4) >= 256;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Effects of a transfer that completed at the edge just passed.
  task automatic apply_pending();
    if (pend_v) begin
      exp_pready[pend_d]  = 1'b0;
      exp_pslverr[pend_d] = 1'b0;
      if (pend_wr) begin
        exp_prdata[pend_d] = 32'd0;
        if (!pend_oob) begin
          for (int b = 0; b < 4; b++)
            if (pend_strb[b]) mdl[pend_d][pend_idx][b*8 +: 8] = pend_data[b*8 +: 8];
        end
      end
      pend_v = 1'b0;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    apply_pending();
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
  endtask

  // abort_kind: 0 none, 1 psel dropped, 2 reset asserted; abort_at = access cycle (1-based).
  task automatic xfer(input int d, input bit wr, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int abort_kind, input int abort_at);
    int w;
    w = (d == 1) ? 3 : 0;
    @(posedge clk); #1;
    apply_pending();
    psel0 = (d == 0); psel3 = (d == 1); penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    for (int k = 1; k <= w + 1; k++) begin
      @(posedge clk); #1;
      if (abort_kind != 0 && k == abort_at) begin
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        if (abort_kind == 2) begin
          rst_n = 1'b0;
          for (int i = 0; i < 2; i++) begin
            exp_pready[i] = 1'b0; exp_pslverr[i] = 1'b0; exp_prdata[i] = 32'd0;
          end
        end
        return;
      end
      penable = 1'b1;
      if (k == w + 1) begin
        exp_pready[d]  = 1'b1;
        exp_pslverr[d] = oob_of(addr);
        if (oob_of(addr)) exp_prdata[d] = 32'd0;
        else if (!wr)     exp_prdata[d] = mdl[d][idx_of(addr)];
        pend_v = 1'b1; pend_d = d; pend_wr = wr; pend_oob = oob_of(addr);
        pend_idx = idx_of(addr); pend_data = data; pend_strb = strb;
      end
    end
  endtask

  // Single compare process against the model, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      checks += 6;
      if (pready0 !== exp_pready[0]) begin errors++; $display("FAIL cmp_pready0 t=%0t got %b expected %b", $time, pready0, exp_pready[0]); end
      if (pslverr0 !== exp_pslverr[0]) begin errors++; $display("FAIL cmp_pslverr0 t=%0t got %b expected %b", $time, pslverr0, exp_pslverr[0]); end
      if (prdata0 !== exp_prdata[0]) begin errors++; $display("FAIL cmp_prdata0 t=%0t got %h expected %h", $time, prdata0, exp_prdata[0]); end
      if (pready3 !== exp_pready[1]) begin errors++; $display("FAIL cmp_pready3 t=%0t got %b expected %b", $time, pready3, exp_pready[1]); end
      if (pslverr3 !== exp_pslverr[1]) begin errors++; $display("FAIL cmp_pslverr3 t=%0t got %b expected %b", $time, pslverr3, exp_pslverr[1]); end
      if (prdata3 !== exp_prdata[1]) begin errors++; $display("FAIL cmp_prdata3 t=%0t got %h expected %h", $time, prdata3, exp_prdata[1]); end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 12'h000; pwdata = 32'd0; pstrb = 4'h0; pend_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_pready[i] = 1'b0; exp_pslverr[i] = 1'b0; exp_prdata[i] = 32'd0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pready0", {31'd0, pready0}, 32'd0);
    chk("rst_prdata0", prdata0, 32'd0);
    chk("rst_pslverr3", {31'd0, pslverr3}, 32'd0);
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait basic write/read.
    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0);
    xfer(0, 1'b0, 12'h010, 32'd0, 4'hF, 0, 0);
    @(negedge clk);
    chk("rd010_pready_first_cycle", {31'd0, pready0}, 32'd1);
    chk("rd010_data", prdata0, 32'hDEADBEEF);

    // Byte strobes, back-to-back.
    xfer(0, 1'b1, 12'h020, 32'h11223344, 4'hF, 0, 0);
    xfer(0, 1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 0, 0);
    xfer(0, 1'b0, 12'h020, 32'd0, 4'h0, 0, 0);
    @(negedge clk);
    chk("rd020_strobe_merge", prdata0, 32'h11BB33DD);

    // Offset bits ignored.
    xfer(0, 1'b0, 12'h013, 32'd0, 4'h0, 0, 0);
    @(negedge clk);
    chk("rd013_offset", prdata0, 32'hDEADBEEF);

    // pstrb = 0 write changes nothing.
    xfer(0, 1'b1, 12'h010, 32'h00000000, 4'h0, 0, 0);
    xfer(0, 1'b0, 12'h010, 32'd0, 4'hF, 0, 0);
    @(negedge clk);
    chk("rd010_after_zero_strb", prdata0, 32'hDEADBEEF);

    // psel & penable without setup: ignored.
    @(posedge clk); #1;
    apply_pending();
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h020; pwdata = 32'd0; pstrb = 4'hF;
    idle();
    xfer(0, 1'b0, 12'h020, 32'd0, 4'h0, 0, 0);
    @(negedge clk);
    chk("rd020_after_violation", prdata0, 32'h11BB33DD);

    // Out-of-range index 256.
    xfer(0, 1'b1, 12'h000, 32'h01020304, 4'hF, 0, 0);
    xfer(0, 1'b1, 12'h400, 32'hCAFEF00D, 4'hF, 0, 0);
    @(negedge clk);
`ifdef APB4_MEM_SLAVE_PSLVERR_EN
    chk("oob_pslverr", {31'd0, pslverr0}, 32'd1);
`else
    chk("oob_pslverr", {31'd0, pslverr0}, 32'd0);
`endif
    xfer(0, 1'b0, 12'h000, 32'd0, 4'h0, 0, 0);
    @(negedge clk);
`ifdef APB4_MEM_SLAVE_PSLVERR_EN
    chk("rd000_after_oob", prdata0, 32'h01020304);
`else
    chk("rd000_after_oob", prdata0, 32'hCAFEF00D);
`endif

    // Three wait states, back-to-back write after read.
    idle();
    xfer(1, 1'b1, 12'h040, 32'h55667788, 4'hF, 0, 0);
    xfer(1, 1'b0, 12'h040, 32'd0, 4'h0, 0, 0);
    @(negedge clk);
    chk("w3_rd040_pready", {31'd0, pready3}, 32'd1);
    chk("w3_rd040_data", prdata3, 32'h55667788);
    xfer(1, 1'b1, 12'h044, 32'h00000099, 4'hF, 0, 0);

    // psel dropped in the 2nd access cycle of a write.
    xfer(1, 1'b1, 12'h040, 32'hFFFFFFFF, 4'hF, 1, 2);
    idle();
    xfer(1, 1'b0, 12'h040, 32'd0, 4'h0, 0, 0);
    @(negedge clk);
    chk("w3_rd040_after_drop", prdata3, 32'h55667788);

    // Reset during a wait cycle.
    xfer(1, 1'b1, 12'h050, 32'h12345678, 4'hF, 0, 0);
    xfer(1, 1'b0, 12'h050, 32'd0, 4'h0, 0, 0);
    xfer(1, 1'b1, 12'h040, 32'h0BADBAD0, 4'hF, 2, 2);
    #1;
    chk("rst_mid_prdata3", prdata3, 32'd0);
    chk("rst_mid_prdata0", prdata0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1, 1'b0, 12'h040, 32'd0, 4'h0, 0, 0);
    @(negedge clk);
    chk("post_rst_rd040", prdata3, 32'h55667788);
    xfer(1, 1'b0, 12'h050, 32'd0, 4'h0, 0, 0);
    @(negedge clk);
    chk("post_rst_rd050", prdata3, 32'h12345678);
    xfer(0, 1'b0, 12'h020, 32'd0, 4'h0, 0, 0);
    @(negedge clk);
    chk("post_rst_rd020", prdata0, 32'h11BB33DD);

    idle();
    idle();
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb4_mem_slave.md
APB4_MEM_SLAVE -- requirements
Module: apb4_mem_slave

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter ADDR_W, default 12: PADDR width in bits; PADDR is a byte address.
REQ-003 Parameter DATA_W, default 32: data width; legal values 8, 16, 32, 64.
REQ-004 Parameter DEPTH, default 256: memory depth in words; power of two; DEPTH*(DATA_W/8) <= 2^ADDR_W.
REQ-005 Parameter WAIT_CYCLES, default 0: wait states per transfer; range 0-15.
REQ-006 Port clk, input, 1: clock; all logic on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port psel, input, 1: slave select.
REQ-009 Port penable, input, 1: access phase.
REQ-010 Port pwrite, input, 1: 1 = write, 0 = read.
REQ-011 Port paddr, input, ADDR_W: byte address.
REQ-012 Port pwdata, input, DATA_W: write data.
REQ-013 Port pstrb, input, DATA_W/8: byte write strobes.
REQ-014 Port prdata, output, DATA_W: read data.
REQ-015 Port pready, output, 1: transfer complete.
REQ-016 Port pslverr, output, 1: error response.

Function
REQ-017 Word index SHALL be paddr >> log2(DATA_W/8); the low offset bits SHALL be ignored.
REQ-018 The FSM SHALL have two states, IDLE and ACCESS.
REQ-019 IDLE -> ACCESS SHALL occur on psel=1 and penable=0; the wait counter SHALL load WAIT_CYCLES.
REQ-020 The access phase SHALL last exactly WAIT_CYCLES+1 cycles: pready=0 for the first WAIT_CYCLES access cycles and pready=1 in the last one.
- WAIT_CYCLES=0 gives a zero-wait transfer, with pready=1 in the first penable cycle.
REQ-021 pready, prdata and pslverr SHALL be registered outputs; pready SHALL be high for exactly one cycle per transfer.
REQ-022 A write SHALL update the memory at the edge where psel & penable & pready are all 1.
- Only bytes with pstrb[i]=1 SHALL change; pstrb=0 completes with no change.
REQ-023 Read data SHALL be valid on prdata in the same cycle as pready=1; pstrb SHALL be ignored on reads.
REQ-024 prdata SHALL hold its last value outside completed reads and SHALL be 0 after a completed write.
REQ-025 ACCESS -> IDLE SHALL occur at the completion edge.
- A new setup phase on the very next cycle SHALL be accepted (back-to-back, no idle cycle).
REQ-026 If psel falls during ACCESS before completion, the FSM SHALL return to IDLE, perform no write, and keep pready=0.
REQ-027 psel=1 and penable=1 seen in IDLE with no preceding setup (protocol violation) SHALL be ignored.
REQ-028 paddr, pwrite, pwdata and pstrb SHALL be sampled at the completion edge.

Reset
REQ-029 While rst_n=0: pready=0, pslverr=0, prdata=0, FSM=IDLE, wait counter=0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no memory write; memory contents SHALL NOT be reset.

Configuration
REQ-031 Macro APB4_MEM_SLAVE_PSLVERR_EN SHALL control error responses.
- Defined: word index >= DEPTH SHALL complete with pready=1, pslverr=1 and prdata=0, with the write suppressed; in-range transfers SHALL have pslverr=0.
- Undefined: pslverr SHALL be tied to 0, and the word index SHALL wrap modulo DEPTH.

Verification
REQ-032 Defaults, write 0xDEADBEEF @0x010 with pstrb=0xF, then read @0x010 -> pready=1 in the first access cycle; prdata=0xDEADBEEF.
REQ-033 Write 0x11223344 @0x020, then write 0xAABBCCDD with pstrb=0x5, then read @0x020 -> prdata=0x11BB33DD.
REQ-034 WAIT_CYCLES=3, read -> pready=0 for 3 access cycles, then 1 for one cycle; back-to-back write accepted on the next cycle.
REQ-035 psel dropped in the 2nd access cycle of a write with WAIT_CYCLES=3 -> no pready; a subsequent read returns the old value.
REQ-036 PSLVERR_EN defined, write @0x400 (index 256) -> pslverr=1 with pready; mem[0] unchanged. Undefined: same write lands in mem[0].
REQ-037 rst_n low during a wait cycle -> outputs at reset values immediately; earlier memory contents readable after reset.
